// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b, LSB first.
// One full-subtractor cell plus a registered borrow handles one bit per clock.
// The operation takes WIDTH clocks and returns one result per WIDTH+2 clocks at best.
//
// Optional build macro SERIAL_SUB_SAT_EN: when defined, an underflowing
// result is clamped to zero on entry to DONE. borrow_out still reports the
// underflow, and the serial diff_bit stream keeps the raw modular bits.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. start_ready is high only in IDLE, and a/b are sampled only on
// that edge. done_valid is high only in DONE, and it holds diff/borrow_out
// stable until the edge where done_ready is high.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             bit_valid,
  output logic             diff_bit,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rs_next;
  logic             br;
  logic             br_next;
  logic             d;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;

  // Subtractor cell: difference bit, next borrow and next result shift value.
  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    rs_next = {d, rs[WIDTH-1:1]};
    last    = (cnt == CW'(WIDTH - 1));
    accept  = start_valid && (state == IDLE);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    bit_valid   = 1'b0;
    diff_bit    = 1'b0;
    done_valid  = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        bit_valid = 1'b1;
        diff_bit  = d;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand and result shift registers, borrow, bit counter and result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      rs         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sa  <= a;
            sb  <= b;
            rs  <= '0;
            br  <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          rs <= rs_next;
          br <= br_next;
          if (last) begin
            // The counter is cleared here rather than left to wrap.
            cnt        <= '0;
            borrow_out <= br_next;
`ifdef SERIAL_SUB_SAT_EN
            diff       <= br_next ? '0 : rs_next;
`else
            diff       <= rs_next;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // DONE and IDLE without accept: the result registers keep their values.
        end
      endcase
    end
  end

endmodule
